// File: rtl/cond_unit_if.sv
// Bundle between the multicycle main FSM and the conditional-execution stage.
// The master side is the FSM/datapath; the slave side is cond_unit.
interface cond_unit_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             NextPC;
    logic             RegW;
    logic             MemW;
    logic             IRWrite;
    logic             cnt_clr;
    logic [3:0]       Flags;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] squash_cnt;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, IRWrite, cnt_clr,
        input  Flags, PCWrite, RegWrite, MemWrite, exec_cnt, squash_cnt
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW, IRWrite, cnt_clr,
        output Flags, PCWrite, RegWrite, MemWrite, exec_cnt, squash_cnt
    );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution stage: evaluates Cond against stored NZCV, gates the FSM's
// raw write strobes, owns the flag register and the retired/squashed counters.
module cond_unit #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    cond_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       r_flags;
    logic             r_cond_pass;
    logic             r_ir_new;
    logic             r_instr_valid;
    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_squash_cnt;
    logic             w_cond_ok;
    logic             w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ok = 1'b0;
        case (bus.Cond)
            4'b0000: w_cond_ok = w_z;
            4'b0001: w_cond_ok = ~w_z;
            4'b0010: w_cond_ok = w_c;
            4'b0011: w_cond_ok = ~w_c;
            4'b0100: w_cond_ok = w_n;
            4'b0101: w_cond_ok = ~w_n;
            4'b0110: w_cond_ok = w_v;
            4'b0111: w_cond_ok = ~w_v;
            4'b1000: w_cond_ok = w_c & ~w_z;
            4'b1001: w_cond_ok = ~w_c | w_z;
            4'b1010: w_cond_ok = (w_n == w_v);
            4'b1011: w_cond_ok = (w_n != w_v);
            4'b1100: w_cond_ok = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ok = w_z | (w_n != w_v);
            4'b1110: w_cond_ok = 1'b1;
            default: w_cond_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags       <= 4'b0000;
            r_cond_pass   <= 1'b0;
            r_ir_new      <= 1'b0;
            r_instr_valid <= 1'b0;
            r_exec_cnt    <= '0;
            r_squash_cnt  <= '0;
        end else begin
            r_ir_new <= bus.IRWrite;
            // Latch only in the decode cycle so the instruction's own flag write
            // cannot change whether it executes.
            if (r_ir_new)
                r_cond_pass <= w_cond_ok;
            if (bus.FlagW[1] && r_cond_pass)
                r_flags[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0] && r_cond_pass)
                r_flags[1:0] <= bus.ALUFlags[1:0];
            if (bus.IRWrite)
                r_instr_valid <= 1'b1;
            // A fetch retires the previous instruction; clear takes priority.
            if (bus.cnt_clr) begin
                r_exec_cnt   <= '0;
                r_squash_cnt <= '0;
            end else if (bus.IRWrite && r_instr_valid) begin
                if (r_cond_pass) begin
                    if (r_exec_cnt != CNT_MAX)
                        r_exec_cnt <= r_exec_cnt + CNT_ONE;
                end else begin
                    if (r_squash_cnt != CNT_MAX)
                        r_squash_cnt <= r_squash_cnt + CNT_ONE;
                end
            end
        end
    end

    assign bus.Flags      = r_flags;
    assign bus.PCWrite    = bus.NextPC | (bus.PCS & r_cond_pass);
    assign bus.RegWrite   = bus.RegW & r_cond_pass;
    assign bus.MemWrite   = bus.MemW & r_cond_pass;
    assign bus.exec_cnt   = r_exec_cnt;
    assign bus.squash_cnt = r_squash_cnt;
endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: multicycle fetch/decode/execute sequences against a
// reference model of flags, condition outcome and retire counters.
module tb_cond_unit;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    cond_unit_if #(.CNT_W(CNT_W)) u_if ();
    cond_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(u_if));

    logic [3:0]       m_flags;
    bit               m_pass;
    bit               m_valid;
    logic [CNT_W-1:0] m_exec;
    logic [CNT_W-1:0] m_squash;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Condition evaluated as base test on Cond[3:1], inverted by Cond[0].
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        logic [2:0] grp;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        grp = c[3:1];
        case (grp)
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    task automatic model_reset();
        m_flags = 4'b0000; m_pass = 0; m_valid = 0; m_exec = '0; m_squash = '0;
    endtask

    task automatic idle_inputs();
        u_if.ALUFlags = 4'b0000; u_if.FlagW = 2'b00; u_if.PCS = 0; u_if.NextPC = 0;
        u_if.RegW = 0; u_if.MemW = 0; u_if.IRWrite = 0; u_if.cnt_clr = 0;
    endtask

    task automatic do_fetch(input bit clr);
        idle_inputs();
        u_if.IRWrite = 1; u_if.NextPC = 1; u_if.cnt_clr = clr;
        #1;
        checks++;
        if (u_if.PCWrite !== 1'b1 || u_if.RegWrite !== 1'b0 || u_if.MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL fetch_strobes: PCWrite=%b RegWrite=%b MemWrite=%b, want 1 0 0",
                     u_if.PCWrite, u_if.RegWrite, u_if.MemWrite);
        end
        @(posedge clk);
        if (clr) begin
            m_exec = '0; m_squash = '0;
        end else if (m_valid) begin
            if (m_pass) begin if (m_exec != '1) m_exec++; end
            else begin if (m_squash != '1) m_squash++; end
        end
        m_valid = 1;
        #1;
        checks++;
        if (u_if.exec_cnt !== m_exec || u_if.squash_cnt !== m_squash) begin
            errors++;
            $display("FAIL counters: exec=%0d squash=%0d, want exec=%0d squash=%0d",
                     u_if.exec_cnt, u_if.squash_cnt, m_exec, m_squash);
        end
    endtask

    task automatic do_decode(input logic [3:0] cond);
        idle_inputs();
        u_if.Cond = cond;
        @(posedge clk);
        m_pass = ref_cond(cond, m_flags);
        #1;
    endtask

    task automatic do_exec(input bit regw, input bit memw, input bit pcs,
                           input logic [1:0] flagw, input logic [3:0] aluf);
        idle_inputs();
        u_if.RegW = regw; u_if.MemW = memw; u_if.PCS = pcs;
        u_if.FlagW = flagw; u_if.ALUFlags = aluf;
        #1;
        checks++;
        if (u_if.RegWrite !== (regw & m_pass) || u_if.MemWrite !== (memw & m_pass) ||
            u_if.PCWrite !== (pcs & m_pass)) begin
            errors++;
            $display("FAIL exec_gating cond=%b flags=%b: Reg/Mem/PC=%b%b%b, want %b%b%b",
                     u_if.Cond, m_flags, u_if.RegWrite, u_if.MemWrite, u_if.PCWrite,
                     regw & m_pass, memw & m_pass, pcs & m_pass);
        end
        @(posedge clk);
        if (m_pass && flagw[1]) m_flags[3:2] = aluf[3:2];
        if (m_pass && flagw[0]) m_flags[1:0] = aluf[1:0];
        #1;
        checks++;
        if (u_if.Flags !== m_flags) begin
            errors++;
            $display("FAIL flags: got %b, want %b", u_if.Flags, m_flags);
        end
    endtask

    task automatic run_instr(input logic [3:0] cond, input bit regw, input bit memw,
                             input bit pcs, input logic [1:0] flagw, input logic [3:0] aluf);
        do_fetch(0);
        do_decode(cond);
        do_exec(regw, memw, pcs, flagw, aluf);
    endtask

    task automatic set_flags(input logic [3:0] f);
        run_instr(4'b1110, 0, 0, 0, 2'b11, f);
    endtask

    task automatic test_reset();
        idle_inputs();
        u_if.Cond = 4'b1110;
        reset = 1;
        model_reset();
        u_if.RegW = 1; u_if.MemW = 1; u_if.PCS = 1; u_if.NextPC = 0;
        #3;
        checks++;
        if (u_if.Flags !== 4'b0000 || u_if.RegWrite !== 1'b0 || u_if.MemWrite !== 1'b0 ||
            u_if.PCWrite !== 1'b0 || u_if.exec_cnt !== '0 || u_if.squash_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: Flags=%b Reg=%b Mem=%b PC=%b exec=%0d squash=%0d",
                     u_if.Flags, u_if.RegWrite, u_if.MemWrite, u_if.PCWrite,
                     u_if.exec_cnt, u_if.squash_cnt);
        end
        u_if.NextPC = 1;
        #1;
        checks++;
        if (u_if.PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL reset_nextpc: PCWrite=%b, want 1", u_if.PCWrite);
        end
        idle_inputs();
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_al();
        run_instr(4'b1110, 1, 0, 0, 2'b00, 4'b1111);
        do_fetch(0);
        checks++;
        if (u_if.exec_cnt !== 4'd1 || u_if.squash_cnt !== 4'd0) begin
            errors++;
            $display("FAIL add_al_count: exec=%0d squash=%0d, want 1 0",
                     u_if.exec_cnt, u_if.squash_cnt);
        end
        do_decode(4'b1110);
        do_exec(0, 0, 0, 2'b00, 4'b0000);
    endtask

    task automatic test_squash_str();
        run_instr(4'b0000, 0, 1, 0, 2'b00, 4'b0000);
        do_fetch(0);
        checks++;
        if (u_if.squash_cnt !== 4'd1 || u_if.exec_cnt !== 4'd2) begin
            errors++;
            $display("FAIL str_squash_count: exec=%0d squash=%0d, want 2 1",
                     u_if.exec_cnt, u_if.squash_cnt);
        end
        do_decode(4'b1110);
        do_exec(0, 0, 0, 2'b00, 4'b0000);
    endtask

    task automatic test_flags_branch();
        set_flags(4'b0100);
        checks++;
        if (u_if.Flags !== 4'b0100) begin
            errors++;
            $display("FAIL subs_flags: got %b, want 0100", u_if.Flags);
        end
        run_instr(4'b0000, 0, 0, 1, 2'b00, 4'b0000);
        run_instr(4'b0001, 0, 0, 1, 2'b00, 4'b0000);
    endtask

    task automatic test_squashed_flagw();
        set_flags(4'b0000);
        run_instr(4'b0000, 1, 0, 0, 2'b11, 4'b0100);
        checks++;
        if (u_if.Flags !== 4'b0000) begin
            errors++;
            $display("FAIL squashed_flagw: Flags=%b, want 0000", u_if.Flags);
        end
        // own flag write must not re-evaluate the latched condition
        run_instr(4'b1110, 0, 0, 0, 2'b10, 4'b0100);
        do_fetch(0);
        do_decode(4'b0001);
        do_exec(1, 0, 0, 2'b11, 4'b0000);
    endtask

    task automatic test_sweep();
        for (int f = 0; f < 16; f++) begin
            set_flags(f[3:0]);
            for (int c = 0; c < 16; c++)
                run_instr(c[3:0], 1, 1, 1, 2'b00, 4'b0000);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            do_fetch($urandom_range(0, 19) == 0);
            do_decode(4'($urandom));
            do_exec(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
        end
    endtask

    task automatic test_saturate_clear_reset();
        do_fetch(1);
        do_decode(4'b1111);
        do_exec(1, 1, 1, 2'b11, 4'b1111);
        for (int i = 0; i < 17; i++) run_instr(4'b1111, 1, 1, 1, 2'b00, 4'b0000);
        do_fetch(0);
        checks++;
        if (u_if.squash_cnt !== 4'hF) begin
            errors++;
            $display("FAIL squash_saturate: squash=%0d, want 15", u_if.squash_cnt);
        end
        do_decode(4'b1110);
        do_exec(0, 0, 0, 2'b00, 4'b0000);
        do_fetch(1);
        checks++;
        if (u_if.squash_cnt !== '0 || u_if.exec_cnt !== '0) begin
            errors++;
            $display("FAIL clear_wins: exec=%0d squash=%0d, want 0 0",
                     u_if.exec_cnt, u_if.squash_cnt);
        end
        do_decode(4'b1110);
        do_exec(0, 0, 0, 2'b11, 4'b1010);
        do_fetch(0);
        do_decode(4'b1110);
        idle_inputs();
        u_if.RegW = 1; u_if.MemW = 1; u_if.PCS = 1;
        #1;
        reset = 1;
        model_reset();
        #1;
        checks++;
        if (u_if.Flags !== 4'b0000 || u_if.RegWrite !== 1'b0 || u_if.MemWrite !== 1'b0 ||
            u_if.PCWrite !== 1'b0 || u_if.exec_cnt !== '0 || u_if.squash_cnt !== '0) begin
            errors++;
            $display("FAIL reset_in_execute: Flags=%b Reg=%b Mem=%b PC=%b exec=%0d squash=%0d",
                     u_if.Flags, u_if.RegWrite, u_if.MemWrite, u_if.PCWrite,
                     u_if.exec_cnt, u_if.squash_cnt);
        end
        idle_inputs();
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        run_instr(4'b1110, 1, 0, 0, 2'b00, 4'b0000);
        run_instr(4'b1110, 0, 0, 0, 2'b00, 4'b0000);
        checks++;
        if (u_if.exec_cnt !== 4'd1 || u_if.squash_cnt !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_count: exec=%0d squash=%0d, want 1 0",
                     u_if.exec_cnt, u_if.squash_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1;
        u_if.Cond = 4'b0000;
        idle_inputs();
        model_reset();
        test_reset();
        test_add_al();
        test_squash_str();
        test_flags_branch();
        test_squashed_flagw();
        test_sweep();
        test_random();
        test_saturate_clear_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1, "timeout");
    end
endmodule
